uart_cfg_bank_mc: RTL and testbench

//  Multi-channel UART configuration register bank; generalises the single-UART 4-register map to NUM_CH channels.
//  Per channel: shadowed CTRL/BAUD registers, STATUS with sticky W1C error bits, and a RESERVED slot.

---
 rtl/uart_cfg_pkg.sv | 14 +
 rtl/uart_cfg_channel.sv | 69 ++++++
 rtl/uart_cfg_bank_mc.sv | 77 +++++++
 tb/tb_uart_cfg_bank_mc.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_cfg_pkg.sv
// uart_cfg_pkg: register map indices, STATUS bit positions, reset constants and commit FSM states
package uart_cfg_pkg;
    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_BAUD   = 2'd1;
    localparam logic [1:0] REG_STATUS = 2'd2;
    localparam logic [1:0] REG_RSVD   = 2'd3;
    localparam int COMMIT_BIT = 15;
    localparam int ST_PE      = 0;
    localparam int ST_FE      = 1;
    localparam int ST_BUSY    = 2;
    localparam int ST_PEND    = 3;
    localparam logic [15:0] BAUD_RST = 16'd5208;
    typedef enum logic {IDLE, PEND} commit_st_t;
endpackage

// File: rtl/uart_cfg_channel.sv
// uart_cfg_channel: one UART's shadow/active CTRL+BAUD, sticky STATUS and commit FSM
//   wr_ctrl/wr_baud/wr_status: decoded write strobes; wr_data: write data
//   busy/err: live UART busy and {frame_err, parity_err} pulses
//   cur: register view before this cycle's write; byp: view as seen through a same-cycle write
//   act_ctrl/act_baud: committed config; update: one-cycle commit pulse
module uart_cfg_channel
    import uart_cfg_pkg::*;
#(
    parameter int DW = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wr_ctrl,
    input  logic               wr_baud,
    input  logic               wr_status,
    input  logic [DW-1:0]      wr_data,
    input  logic               busy,
    input  logic [1:0]         err,
    output logic [3:0][DW-1:0] cur,
    output logic [3:0][DW-1:0] byp,
    output logic [DW-1:0]      act_ctrl,
    output logic [DW-1:0]      act_baud,
    output logic               update
);
    commit_st_t st;
    logic [DW-1:0] sh_ctrl, sh_baud, wd_ctrl;
    logic [1:0] sticky, post, sticky_nx;
    logic commit;
    always_comb begin
        wd_ctrl = wr_data;
        wd_ctrl[COMMIT_BIT] = 1'b0;
        commit = wr_ctrl && wr_data[COMMIT_BIT];
        // a same-cycle error pulse overrides the W1C clear
        post = (sticky & ~wr_data[1:0]) | err;
        sticky_nx = wr_status ? post : (sticky | err);
        cur = '0;
        byp = '0;
        cur[REG_CTRL] = sh_ctrl;
        cur[REG_BAUD] = sh_baud;
        cur[REG_STATUS][ST_PEND:ST_PE] = {st == PEND, busy, sticky};
        cur[REG_RSVD] = '0;
        byp[REG_CTRL] = wd_ctrl;
        byp[REG_BAUD] = wr_data;
        byp[REG_STATUS][ST_PEND:ST_PE] = {st == PEND, busy, post};
        byp[REG_RSVD] = '0;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            st       <= IDLE;
            sh_ctrl  <= '0;
            sh_baud  <= DW'(BAUD_RST);
            act_ctrl <= '0;
            act_baud <= DW'(BAUD_RST);
            sticky   <= '0;
            update   <= 1'b0;
        end else begin
            sticky <= sticky_nx;
            if (wr_ctrl) sh_ctrl <= wd_ctrl;
            if (wr_baud) sh_baud <= wr_data;
            update <= st == PEND && !busy;
            if (st == PEND && !busy) begin
                act_ctrl <= sh_ctrl;
                act_baud <= sh_baud;
            end
            // a fresh COMMIT on the commit edge re-arms so the newer shadow gets committed too
            st <= (commit || (st == PEND && busy)) ? PEND : IDLE;
        end
    end
endmodule

// File: rtl/uart_cfg_bank_mc.sv
// uart_cfg_bank_mc: multi-channel UART config bank with shadowed commit, sticky status and two read ports
//   wr_en/wr_addr/wr_data: host write, address = {ch, reg[1:0]}
//   rd_addr_a/b, rd_data_a/b: independent read ports (combinational or registered)
//   uart_busy/uart_error: per-channel live busy and {frame_err, parity_err} pulses
//   cfg_ctrl/cfg_baud/cfg_update: active config per channel and commit pulses
//   addr_err: pulse the cycle after any out-of-range access
module uart_cfg_bank_mc
    import uart_cfg_pkg::*;
#(
    parameter int DATA_WIDTH   = 16,
    parameter int NUM_CH       = 4,
    parameter int READ_LATENCY = 0,
    parameter int AW           = $clog2(NUM_CH*4) + 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en,
    input  logic [AW-1:0]              wr_addr,
    input  logic [DATA_WIDTH-1:0]      wr_data,
    input  logic [AW-1:0]              rd_addr_a,
    output logic [DATA_WIDTH-1:0]      rd_data_a,
    input  logic [AW-1:0]              rd_addr_b,
    output logic [DATA_WIDTH-1:0]      rd_data_b,
    input  logic [NUM_CH-1:0]          uart_busy,
    input  logic [2*NUM_CH-1:0]        uart_error,
    output logic [NUM_CH*DATA_WIDTH-1:0] cfg_ctrl,
    output logic [NUM_CH*DATA_WIDTH-1:0] cfg_baud,
    output logic [NUM_CH-1:0]          cfg_update,
    output logic                       addr_err
);
    localparam int DW = DATA_WIDTH;
    localparam logic [AW-1:0] LIMIT = AW'(NUM_CH*4);
    logic [3:0][DW-1:0] cur [NUM_CH];
    logic [3:0][DW-1:0] byp [NUM_CH];
    logic [DW-1:0] va, vb;
    logic hit_a, hit_b;
    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        uart_cfg_channel #(.DW(DW)) u_ch (
            .clk      (clk),
            .rst      (rst),
            .wr_ctrl  (wr_en && wr_addr == AW'(c*4 + int'(REG_CTRL))),
            .wr_baud  (wr_en && wr_addr == AW'(c*4 + int'(REG_BAUD))),
            .wr_status(wr_en && wr_addr == AW'(c*4 + int'(REG_STATUS))),
            .wr_data  (wr_data),
            .busy     (uart_busy[c]),
            .err      (uart_error[2*c +: 2]),
            .cur      (cur[c]),
            .byp      (byp[c]),
            .act_ctrl (cfg_ctrl[c*DW +: DW]),
            .act_baud (cfg_baud[c*DW +: DW]),
            .update   (cfg_update[c])
        );
    end
    // out-of-range addresses match no channel and fall through to zero
    always_comb begin
        hit_a = READ_LATENCY == 0 && wr_en && rd_addr_a == wr_addr;
        hit_b = READ_LATENCY == 0 && wr_en && rd_addr_b == wr_addr;
        va = '0;
        vb = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            va = (rd_addr_a >> 2) == AW'(i) ? (hit_a ? byp[i][rd_addr_a[1:0]] : cur[i][rd_addr_a[1:0]]) : va;
            vb = (rd_addr_b >> 2) == AW'(i) ? (hit_b ? byp[i][rd_addr_b[1:0]] : cur[i][rd_addr_b[1:0]]) : vb;
        end
    end
    if (READ_LATENCY == 1) begin : g_reg
        always_ff @(posedge clk) begin
            rd_data_a <= rst ? '0 : va;
            rd_data_b <= rst ? '0 : vb;
        end
    end else begin : g_comb
        assign rd_data_a = va;
        assign rd_data_b = vb;
    end
    always_ff @(posedge clk) begin
        addr_err <= rst ? 1'b0 : ((wr_en && wr_addr >= LIMIT) || rd_addr_a >= LIMIT || rd_addr_b >= LIMIT);
    end
endmodule

// File: tb/tb_uart_cfg_bank_mc.sv
// tb_uart_cfg_bank_mc: directed and random checks of both read latencies against a register-map model
module tb_uart_cfg_bank_mc;
    localparam int N = 4;
    localparam int DW = 16;
    localparam int AW = 5;
    logic clk = 1'b0;
    logic rst, wr_en;
    logic [AW-1:0] wr_addr, rd_addr_a, rd_addr_b;
    logic [DW-1:0] wr_data;
    logic [N-1:0] uart_busy;
    logic [2*N-1:0] uart_error;
    logic [DW-1:0] rda0, rdb0, rda1, rdb1;
    logic [N*DW-1:0] cc0, cb0, cc1, cb1;
    logic [N-1:0] up0, up1;
    logic ae0, ae1;
    logic [DW-1:0] m_sh_c [N], m_sh_b [N], m_ac [N], m_ab [N];
    logic m_pe [N], m_fe [N], m_pend [N];
    logic [N-1:0] e_upd;
    logic e_aerr;
    logic [DW-1:0] e_ra1, e_rb1;
    logic [N*DW-1:0] ec, eb;
    int total = 0;
    int bad = 0;
    always #5 clk = ~clk;
    uart_cfg_bank_mc #(.DATA_WIDTH(DW), .NUM_CH(N), .READ_LATENCY(0)) u_lat0 (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr_a(rd_addr_a), .rd_data_a(rda0), .rd_addr_b(rd_addr_b), .rd_data_b(rdb0),
        .uart_busy(uart_busy), .uart_error(uart_error), .cfg_ctrl(cc0), .cfg_baud(cb0),
        .cfg_update(up0), .addr_err(ae0)
    );
    uart_cfg_bank_mc #(.DATA_WIDTH(DW), .NUM_CH(N), .READ_LATENCY(1)) u_lat1 (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr_a(rd_addr_a), .rd_data_a(rda1), .rd_addr_b(rd_addr_b), .rd_data_b(rdb1),
        .uart_busy(uart_busy), .uart_error(uart_error), .cfg_ctrl(cc1), .cfg_baud(cb1),
        .cfg_update(up1), .addr_err(ae1)
    );
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask
    function automatic logic [DW-1:0] mread(input logic [AW-1:0] a, input logic use_byp);
        int ch, r;
        if (int'(a) >= 4*N) return '0;
        ch = int'(a) / 4;
        r = int'(a) % 4;
        if (use_byp && wr_en && a == wr_addr) begin
            if (r == 0) return wr_data & 16'h7fff;
            if (r == 1) return wr_data;
            if (r == 2) return DW'({m_pend[ch], uart_busy[ch],
                                    (m_fe[ch] & ~wr_data[1]) | uart_error[2*ch+1],
                                    (m_pe[ch] & ~wr_data[0]) | uart_error[2*ch]});
            return '0;
        end
        if (r == 0) return m_sh_c[ch];
        if (r == 1) return m_sh_b[ch];
        if (r == 2) return DW'({m_pend[ch], uart_busy[ch], m_fe[ch], m_pe[ch]});
        return '0;
    endfunction
    task automatic model_edge();
        logic w0, w1, w2;
        if (rst) begin
            for (int ch = 0; ch < N; ch++) begin
                m_sh_c[ch] = '0; m_ac[ch] = '0;
                m_sh_b[ch] = 16'd5208; m_ab[ch] = 16'd5208;
                m_pe[ch] = 1'b0; m_fe[ch] = 1'b0; m_pend[ch] = 1'b0;
            end
            e_upd = '0; e_aerr = 1'b0; e_ra1 = '0; e_rb1 = '0;
            return;
        end
        e_ra1 = mread(rd_addr_a, 1'b0);
        e_rb1 = mread(rd_addr_b, 1'b0);
        e_aerr = (wr_en && int'(wr_addr) >= 4*N) || int'(rd_addr_a) >= 4*N || int'(rd_addr_b) >= 4*N;
        for (int ch = 0; ch < N; ch++) begin
            w0 = wr_en && int'(wr_addr) == 4*ch;
            w1 = wr_en && int'(wr_addr) == 4*ch + 1;
            w2 = wr_en && int'(wr_addr) == 4*ch + 2;
            e_upd[ch] = m_pend[ch] && !uart_busy[ch];
            if (e_upd[ch]) begin
                m_ac[ch] = m_sh_c[ch];
                m_ab[ch] = m_sh_b[ch];
            end
            m_pend[ch] = (w0 && wr_data[15]) || (m_pend[ch] && uart_busy[ch]);
            if (w2) begin
                m_pe[ch] = m_pe[ch] & ~wr_data[0];
                m_fe[ch] = m_fe[ch] & ~wr_data[1];
            end
            m_pe[ch] = m_pe[ch] | uart_error[2*ch];
            m_fe[ch] = m_fe[ch] | uart_error[2*ch+1];
            if (w0) m_sh_c[ch] = wr_data & 16'h7fff;
            if (w1) m_sh_b[ch] = wr_data;
        end
    endtask
    task automatic step();
        if (!rst) begin
            #1;
            chk("rd_a_lat0", rda0, mread(rd_addr_a, 1'b1));
            chk("rd_b_lat0", rdb0, mread(rd_addr_b, 1'b1));
        end
        model_edge();
        @(posedge clk);
        #1;
        for (int ch = 0; ch < N; ch++) begin
            ec[ch*DW +: DW] = m_ac[ch];
            eb[ch*DW +: DW] = m_ab[ch];
        end
        chk("cfg_ctrl_lat0", cc0, ec);
        chk("cfg_ctrl_lat1", cc1, ec);
        chk("cfg_baud_lat0", cb0, eb);
        chk("cfg_baud_lat1", cb1, eb);
        chk("cfg_update_lat0", up0, e_upd);
        chk("cfg_update_lat1", up1, e_upd);
        chk("addr_err_lat0", ae0, e_aerr);
        chk("addr_err_lat1", ae1, e_aerr);
        chk("rd_a_lat1", rda1, e_ra1);
        chk("rd_b_lat1", rdb1, e_rb1);
    endtask
    task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        step();
        wr_en = 1'b0;
    endtask
    initial begin
        rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        rd_addr_a = 5'd0; rd_addr_b = 5'd1; uart_busy = '0; uart_error = '0;
        @(posedge clk);
        #1;
        step();
        step();
        rst = 1'b0;
        step();
        for (int ch = 0; ch < N; ch++) begin
            rd_addr_a = AW'(4*ch); rd_addr_b = AW'(4*ch + 1);
            #1;
            chk("rst_ctrl", rda0, 16'd0);
            chk("rst_baud", rdb0, 16'd5208);
            step();
            rd_addr_a = AW'(4*ch + 2); rd_addr_b = 5'd3;
            #1;
            chk("rst_status", rda0, 16'd0);
            chk("rst_rsvd", rdb0, 16'd0);
            step();
        end
        rd_addr_a = 5'd0; rd_addr_b = 5'd1;
        wr(5'd5, 16'd4800);
        wr(5'd4, 16'h8003);
        step();
        chk("idle_commit_pulse", up0, 4'b0010);
        chk("idle_commit_baud", cb0[16 +: 16], 16'd4800);
        chk("idle_commit_ctrl", cc0[16 +: 16], 16'd3);
        chk("idle_other_baud", cb0[0 +: 16], 16'd5208);
        step();
        chk("idle_pulse_once", up0, 4'b0000);
        uart_busy[2] = 1'b1;
        rd_addr_a = 5'd10;
        wr(5'd8, 16'h8001);
        for (int k = 0; k < 10; k++) begin
            #1;
            chk("busy_pending", rda0[3], 1'b1);
            chk("busy_no_update", up0[2], 1'b0);
            step();
        end
        uart_busy[2] = 1'b0;
        step();
        chk("busy_release_update", up0[2], 1'b1);
        rd_addr_a = 5'd2;
        uart_error = 8'b0000_0001;
        step();
        uart_error = '0;
        step();
        #1;
        chk("sticky_pe_set", rda0, 16'd1);
        wr(5'd2, 16'd1);
        #1;
        chk("sticky_pe_clear", rda0, 16'd0);
        uart_error = 8'b0000_0001;
        wr(5'd2, 16'd1);
        uart_error = '0;
        #1;
        chk("sticky_set_wins", rda0, 16'd1);
        rd_addr_a = 5'd4;
        wr_en = 1'b1; wr_addr = 5'd4; wr_data = 16'd7;
        #1;
        chk("raw_bypass_lat0", rda0, 16'd7);
        step();
        wr_en = 1'b0;
        chk("raw_old_lat1", rda1, 16'd3);
        rd_addr_a = 5'd0;
        wr(5'd16, 16'hffff);
        chk("oor_addr_err", ae0, 1'b1);
        step();
        chk("oor_addr_err_once", ae0, 1'b0);
        rd_addr_b = 5'd17;
        #1;
        chk("oor_read_b", rdb0, 16'd0);
        step();
        rd_addr_b = 5'd1;
        uart_busy[3] = 1'b1;
        wr(5'd12, 16'h80aa);
        rst = 1'b1;
        step();
        rst = 1'b0;
        uart_busy[3] = 1'b0;
        step();
        chk("rst_pend_no_update", up0[3], 1'b0);
        chk("rst_pend_ctrl", cc0[48 +: 16], 16'd0);
        for (int k = 0; k < 400; k++) begin
            wr_en = 1'($urandom_range(0, 1));
            wr_addr = AW'($urandom_range(0, 19));
            wr_data = DW'($urandom);
            uart_busy = N'($urandom);
            uart_error = ($urandom_range(0, 7) == 0) ? (2*N)'($urandom) : '0;
            rd_addr_a = AW'($urandom_range(0, 19));
            rd_addr_b = AW'($urandom_range(0, 19));
            step();
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
